// File: rtl/packet_framer.sv
// Triggered multi-channel packet framer: captures decimated ADC sample sets
// and serialises each set into one word per clock with SoP/EoP framing.
module packet_framer #(
    parameter int DATA_WIDTH   = 14,
    parameter int CHANNELS     = 4,
    parameter int LENGTH_WIDTH = 12,
    parameter int DECIM_WIDTH  = 8,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           ipClk,
    input  logic                           ipnReset,
    input  logic                           ipEnable,
    input  logic                           ipTrigger,
    input  logic [LENGTH_WIDTH-1:0]        ipLength,
    input  logic [DECIM_WIDTH-1:0]         ipDecimate,
    input  logic                           ipOffsetBinary,
    input  logic                           ipClearFlags,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ipSamples,
    input  logic                           ipValid,
    output logic                           opSoP,
    output logic                           opEoP,
    output logic [DATA_WIDTH-1:0]          opData,
    output logic [CHAN_W-1:0]              opChannel,
    output logic                           opValid,
    output logic                           opBusy,
    output logic                           opOverrun,
    output logic                           opTriggerMissed,
    output logic [15:0]                    opPacketCount
);

    localparam int CNT_W = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {
        Idle,
        Sampling,
        Flush
    } state_t;

    state_t                        state;
    state_t                        nextState;

    logic                          trigPrev;
    logic [LENGTH_WIDTH-1:0]       lenReg;
    logic [DECIM_WIDTH-1:0]        decReg;
    logic                          offReg;
    logic [LENGTH_WIDTH-1:0]       setCount;
    logic [LENGTH_WIDTH-1:0]       setCountInc;
    logic [DECIM_WIDTH-1:0]        decimCount;
    logic [CHANNELS*DATA_WIDTH-1:0] holdReg;
    logic [CNT_W-1:0]              serCnt;
    logic [CNT_W-1:0]              serIdx;
    logic                          serLast;
    logic [DATA_WIDTH-1:0]         serWord;
    logic [DATA_WIDTH-1:0]         msbMask;

    logic trigEdge;
    logic serIdle;
    logic validSampling;
    logic decimSkip;
    logic take;
    logic accept;
    logic drop;
    logic lastSet;
    logic startPkt;
    logic missEvt;
    logic flushDone;

    always_comb begin
        trigEdge      = ipTrigger & ~trigPrev;
        serIdle       = (serCnt == '0);
        validSampling = (state == Sampling) && ipValid;
        decimSkip     = validSampling && (decimCount != '0);
        take          = validSampling && (decimCount == '0);
        accept        = take && serIdle;
        drop          = take && !serIdle;
        setCountInc   = setCount + LENGTH_WIDTH'(1);
        lastSet       = (setCountInc == lenReg);
        startPkt      = (state == Idle) && trigEdge && ipEnable && (ipLength != '0);
        missEvt       = (state != Idle) && trigEdge && ipEnable;
        flushDone     = (state == Flush) && serIdle;
        // serCnt counts channels still to emit, so the next one is CHANNELS-serCnt
        serIdx        = CNT_W'(CHANNELS) - serCnt;
        serWord       = holdReg[serIdx*DATA_WIDTH +: DATA_WIDTH];
        msbMask       = {offReg, {(DATA_WIDTH-1){1'b0}}};

        nextState = state;
        case (state)
            Idle:     if (startPkt) nextState = Sampling;
            Sampling: if (accept && lastSet) nextState = Flush;
            Flush:    if (serIdle) nextState = Idle;
            default:  nextState = Idle;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) state <= Idle;
        else           state <= nextState;
    end

    assign opBusy = (state != Idle);

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            trigPrev        <= 1'b1;
            lenReg          <= '0;
            decReg          <= '0;
            offReg          <= 1'b0;
            setCount        <= '0;
            decimCount      <= '0;
            holdReg         <= '0;
            serCnt          <= '0;
            serLast         <= 1'b0;
            opSoP           <= 1'b0;
            opEoP           <= 1'b0;
            opData          <= '0;
            opChannel       <= '0;
            opValid         <= 1'b0;
            opOverrun       <= 1'b0;
            opTriggerMissed <= 1'b0;
            opPacketCount   <= '0;
        end else begin
            trigPrev <= ipTrigger;

            if (startPkt) begin
                lenReg     <= ipLength;
                decReg     <= ipDecimate;
                offReg     <= ipOffsetBinary;
                setCount   <= '0;
                decimCount <= '0;
            end

            if (decimSkip) decimCount <= decimCount - DECIM_WIDTH'(1);
            else if (take) decimCount <= decReg;

            // Channel 0 goes straight from the input; the rest come from holdReg
            if (accept) begin
                setCount  <= setCountInc;
                holdReg   <= ipSamples;
                serLast   <= lastSet;
                serCnt    <= CNT_W'(CHANNELS - 1);
                opValid   <= 1'b1;
                opSoP     <= (setCount == '0);
                opEoP     <= lastSet && (CHANNELS == 1);
                opData    <= ipSamples[DATA_WIDTH-1:0] ^ msbMask;
                opChannel <= '0;
            end else if (!serIdle) begin
                serCnt    <= serCnt - CNT_W'(1);
                opValid   <= 1'b1;
                opSoP     <= 1'b0;
                opEoP     <= serLast && (serCnt == CNT_W'(1));
                opData    <= serWord ^ msbMask;
                opChannel <= CHAN_W'(serIdx);
            end else begin
                opValid   <= 1'b0;
                opSoP     <= 1'b0;
                opEoP     <= 1'b0;
                opData    <= '0;
                opChannel <= '0;
            end

            opOverrun       <= (opOverrun & ~ipClearFlags) | drop;
            opTriggerMissed <= (opTriggerMissed & ~ipClearFlags) | missEvt;

            if (flushDone) opPacketCount <= opPacketCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: directed and random stimulus against an
// event-level reference model of packets, decimation and overrun.
module tb_packet_framer;

    localparam int DW = 14;
    localparam int CH = 4;
    localparam int LW = 12;
    localparam int DECW = 8;
    localparam int CW = 2;

    logic              ipClk = 1'b0;
    logic              ipnReset;
    logic              ipEnable;
    logic              ipTrigger;
    logic [LW-1:0]     ipLength;
    logic [DECW-1:0]   ipDecimate;
    logic              ipOffsetBinary;
    logic              ipClearFlags;
    logic [CH*DW-1:0]  ipSamples;
    logic              ipValid;
    logic              opSoP;
    logic              opEoP;
    logic [DW-1:0]     opData;
    logic [CW-1:0]     opChannel;
    logic              opValid;
    logic              opBusy;
    logic              opOverrun;
    logic              opTriggerMissed;
    logic [15:0]       opPacketCount;

    packet_framer #(
        .DATA_WIDTH(DW),
        .CHANNELS(CH),
        .LENGTH_WIDTH(LW),
        .DECIM_WIDTH(DECW)
    ) dut (
        .ipClk(ipClk),
        .ipnReset(ipnReset),
        .ipEnable(ipEnable),
        .ipTrigger(ipTrigger),
        .ipLength(ipLength),
        .ipDecimate(ipDecimate),
        .ipOffsetBinary(ipOffsetBinary),
        .ipClearFlags(ipClearFlags),
        .ipSamples(ipSamples),
        .ipValid(ipValid),
        .opSoP(opSoP),
        .opEoP(opEoP),
        .opData(opData),
        .opChannel(opChannel),
        .opValid(opValid),
        .opBusy(opBusy),
        .opOverrun(opOverrun),
        .opTriggerMissed(opTriggerMissed),
        .opPacketCount(opPacketCount)
    );

    always #5 ipClk = ~ipClk;

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
        int          ch;
        bit          sop;
        bit          eop;
    } word_t;

    word_t expQ[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    bit          mBusy;
    int          mLen;
    int          mDec;
    bit          mOff;
    int          mSets;
    int          mSkip;
    int          mLastAccept;
    bit          mPrevTrig;
    bit          mOverrun;
    bit          mMissed;
    logic [15:0] mCount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 1'b0; mLen = 0; mDec = 0; mOff = 1'b0; mSets = 0; mSkip = 0;
        mLastAccept = 0; mPrevTrig = 1'b1; mOverrun = 1'b0; mMissed = 1'b0;
        mCount = '0;
        expQ.delete();
    endtask

    task automatic modelStep();
        bit    edgeSeen;
        bit    ov;
        bit    miss;
        word_t w;
        if (!ipnReset) begin
            modelReset();
            return;
        end
        edgeSeen = ipTrigger && !mPrevTrig;
        mPrevTrig = ipTrigger;
        ov = 1'b0;
        miss = 1'b0;
        if (!mBusy) begin
            if (edgeSeen && ipEnable && ipLength != 0) begin
                mBusy = 1'b1; mLen = int'(ipLength); mDec = int'(ipDecimate);
                mOff = ipOffsetBinary; mSets = 0; mSkip = 0; mLastAccept = cyc - CH;
            end
        end else begin
            if (edgeSeen && ipEnable) miss = 1'b1;
            if (mSets < mLen && ipValid) begin
                if (mSkip > 0) mSkip--;
                else begin
                    mSkip = mDec;
                    if (cyc - mLastAccept >= CH) begin
                        for (int k = 0; k < CH; k++) begin
                            w.cyc  = cyc + 1 + k;
                            w.data = ipSamples[k*DW +: DW] ^ (mOff ? 14'h2000 : 14'h0000);
                            w.ch   = k;
                            w.sop  = (mSets == 0) && (k == 0);
                            w.eop  = (mSets == mLen - 1) && (k == CH - 1);
                            expQ.push_back(w);
                        end
                        mLastAccept = cyc;
                        mSets++;
                    end else ov = 1'b1;
                end
            end else if (mSets == mLen && cyc >= mLastAccept + CH) begin
                mBusy = 1'b0;
                mCount = mCount + 16'd1;
            end
        end
        mOverrun = (mOverrun && !ipClearFlags) || ov;
        mMissed  = (mMissed && !ipClearFlags) || miss;
    endtask

    task automatic checkOutputs();
        bit ev;
        ev = (expQ.size() != 0) && (expQ[0].cyc == cyc);
        check("valid", 32'(opValid), 32'(ev));
        if (ev) begin
            check("data", 32'(opData), 32'(expQ[0].data));
            check("chan", 32'(opChannel), 32'(expQ[0].ch));
            check("sop", 32'(opSoP), 32'(expQ[0].sop));
            check("eop", 32'(opEoP), 32'(expQ[0].eop));
            void'(expQ.pop_front());
        end else begin
            check("sop_idle", 32'(opSoP), 32'd0);
            check("eop_idle", 32'(opEoP), 32'd0);
        end
        check("busy", 32'(opBusy), 32'(mBusy));
        check("overrun", 32'(opOverrun), 32'(mOverrun));
        check("trig_missed", 32'(opTriggerMissed), 32'(mMissed));
        check("pkt_count", 32'(opPacketCount), 32'(mCount));
    endtask

    task automatic tick();
        checkOutputs();
        modelStep();
        @(posedge ipClk);
        #1;
        cyc++;
    endtask

    function automatic logic [CH*DW-1:0] randSamples();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CH*DW-1:0];
    endfunction

    function automatic logic [CH*DW-1:0] patSamples(input int i);
        logic [CH*DW-1:0] s;
        for (int k = 0; k < CH; k++) s[k*DW +: DW] = DW'(256 * i + k);
        return s;
    endfunction

    task automatic doReset();
        ipnReset = 1'b0;
        #1;
        check("rst_valid", 32'(opValid), 32'd0);
        check("rst_sop", 32'(opSoP), 32'd0);
        check("rst_eop", 32'(opEoP), 32'd0);
        check("rst_data", 32'(opData), 32'd0);
        check("rst_chan", 32'(opChannel), 32'd0);
        check("rst_busy", 32'(opBusy), 32'd0);
        check("rst_overrun", 32'(opOverrun), 32'd0);
        check("rst_missed", 32'(opTriggerMissed), 32'd0);
        check("rst_count", 32'(opPacketCount), 32'd0);
        modelReset();
        ipValid = 1'b0;
        repeat (2) tick();
        ipnReset = 1'b1;
    endtask

    task automatic pulseTrig(input int len, input int dec, input bit off);
        ipLength = LW'(len);
        ipDecimate = DECW'(dec);
        ipOffsetBinary = off;
        ipTrigger = 1'b1;
        ipValid = 1'b0;
        tick();
        ipTrigger = 1'b0;
    endtask

    task automatic feedOne(input logic [CH*DW-1:0] s, input int spacing);
        ipValid = 1'b1;
        ipSamples = s;
        tick();
        ipValid = 1'b0;
        repeat (spacing - 1) tick();
    endtask

    task automatic feedSets(input int n, input int spacing, input bit pattern);
        for (int i = 0; i < n; i++) feedOne(pattern ? patSamples(i) : randSamples(), spacing);
    endtask

    task automatic idle(input int n);
        ipValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clearFlags();
        ipClearFlags = 1'b1;
        tick();
        ipClearFlags = 1'b0;
    endtask

    // Keeps valid asserted so an unfinished packet can always complete
    task automatic waitIdle(input int budget);
        int i;
        i = 0;
        while (opBusy && i < budget) begin
            ipValid = 1'b1;
            ipSamples = randSamples();
            tick();
            i++;
        end
        ipValid = 1'b0;
        check("idle_timeout", 32'(opBusy), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ipnReset = 1'b1; ipEnable = 1'b1; ipTrigger = 1'b1; ipLength = '0;
        ipDecimate = '0; ipOffsetBinary = 1'b0; ipClearFlags = 1'b0;
        ipSamples = '0; ipValid = 1'b0;
        #2;
        doReset();
        // Trigger held high through reset must not fire
        idle(3);
        ipTrigger = 1'b0;
        idle(2);

        // Basic packet: 3 sets, spacing 4
        pulseTrig(3, 0, 1'b0);
        feedSets(3, 4, 1'b1);
        waitIdle(20);
        check("count_after_first", 32'(opPacketCount), 32'd1);

        // Decimation by 3: sets 0, 3, 6 kept
        pulseTrig(3, 2, 1'b0);
        feedSets(9, 4, 1'b1);
        waitIdle(20);

        // Offset binary MSB inversion
        pulseTrig(2, 0, 1'b1);
        feedOne({randSamples() >> DW, 14'h2000}, 4);
        feedOne({randSamples() >> DW, 14'h1FFF}, 4);
        waitIdle(20);

        // Overrun with spacing 2, then clear
        pulseTrig(4, 0, 1'b0);
        feedSets(8, 2, 1'b0);
        waitIdle(40);
        idle(2);
        clearFlags();
        idle(2);

        // Trigger while busy
        pulseTrig(3, 0, 1'b0);
        feedSets(1, 4, 1'b0);
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        feedSets(2, 4, 1'b0);
        waitIdle(20);
        clearFlags();

        // Reset mid-packet then a fresh packet
        pulseTrig(5, 0, 1'b0);
        feedSets(2, 4, 1'b0);
        ipValid = 1'b1;
        ipSamples = randSamples();
        tick();
        tick();
        doReset();
        idle(2);
        pulseTrig(2, 1, 1'b0);
        feedSets(4, 4, 1'b1);
        waitIdle(20);

        // Zero length and disabled triggers are ignored
        pulseTrig(0, 0, 1'b0);
        idle(3);
        ipEnable = 1'b0;
        pulseTrig(2, 0, 1'b0);
        idle(3);
        ipEnable = 1'b1;

        // Enable falling mid-packet does not abort
        pulseTrig(2, 0, 1'b0);
        ipEnable = 1'b0;
        feedSets(2, 4, 1'b0);
        waitIdle(20);
        ipEnable = 1'b1;

        // Back-to-back: retrigger in the first idle cycle
        pulseTrig(1, 0, 1'b0);
        feedSets(1, 1, 1'b0);
        for (int i = 0; i < 10 && mBusy; i++) tick();
        pulseTrig(2, 0, 1'b1);
        feedSets(2, 5, 1'b0);
        waitIdle(20);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            ipTrigger = ($urandom_range(0, 29) == 0) ? 1'b1 : (ipTrigger && ($urandom_range(0, 3) != 0));
            ipEnable = ($urandom_range(0, 15) != 0);
            ipLength = LW'($urandom_range(0, 6));
            ipDecimate = DECW'($urandom_range(0, 3));
            ipOffsetBinary = 1'($urandom_range(0, 1));
            ipValid = ($urandom_range(0, 2) == 0);
            ipSamples = randSamples();
            ipClearFlags = ($urandom_range(0, 49) == 0);
            tick();
        end
        ipTrigger = 1'b0;
        ipClearFlags = 1'b0;
        ipEnable = 1'b1;
        waitIdle(200);
        clearFlags();
        idle(2);

        // Maximum length packet
        pulseTrig(4095, 0, 1'b0);
        waitIdle(20000);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
